// File: rtl/mux_pkg.sv
// Shared definitions for the Hack word multiplexers: word width and select codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux_pkg;

   // Hack machine word width; default data width of the word muxes.
   localparam int WORD_W = 16;

   // Width of the 8-way select bus.
   localparam int SEL_W = 3;

   // Binary select encodings, MSB first, one per input lane a..h.
   typedef enum logic [SEL_W-1:0] {
      SEL_A = 3'd0,
      SEL_B = 3'd1,
      SEL_C = 3'd2,
      SEL_D = 3'd3,
      SEL_E = 3'd4,
      SEL_F = 3'd5,
      SEL_G = 3'd6,
      SEL_H = 3'd7
   } sel_e;

   // True when the select code addresses the upper bank (e..h).
   function automatic logic sel_is_high(input logic [SEL_W-1:0] s);
      return s[SEL_W-1];
   endfunction

endpackage

// File: rtl/mux_8way_16_if.sv
// Bus bundle for the 8-way word mux: eight data words, select, selected word.
// Latency: n/a (signal bundle only).
// Backpressure: none; plain combinational data path, no handshake.
// Ports: a..h data words, sel select, out selected word,
//        out_q registered copy (only with MUX8WAY16_OUT_REG_EN defined).
// master drives data and select; slave (the mux) drives the results.
interface mux_8way_16_if #(
   parameter int WIDTH = mux_pkg::WORD_W
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] e;
   logic [WIDTH-1:0] f;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] h;
   logic [2:0]       sel;
   logic [WIDTH-1:0] out;
`ifdef MUX8WAY16_OUT_REG_EN
   logic [WIDTH-1:0] out_q;

   modport master (
      output a, b, c, d, e, f, g, h, sel,
      input  out, out_q
   );

   modport slave (
      input  a, b, c, d, e, f, g, h, sel,
      output out, out_q
   );
`else
   modport master (
      output a, b, c, d, e, f, g, h, sel,
      input  out
   );

   modport slave (
      input  a, b, c, d, e, f, g, h, sel,
      output out
   );
`endif

endinterface

// File: rtl/mux_4way_16.sv
// 4:1 word multiplexer, one bank of the 8-way mux.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: sel (2-bit lane select), a..d data words, y selected word.
module mux_4way_16 #(
   parameter int WIDTH = mux_pkg::WORD_W
) (
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (sel)
         2'd0:    y = a;
         2'd1:    y = b;
         2'd2:    y = c;
         2'd3:    y = d;
         // Only reachable with X/Z on sel in 4-state simulation.
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/mux_8way_16.sv
// 8:1 word multiplexer for the Hack datapath (RAM8 read-back and similar).
// Latency: out 0 cycles; out_q 1 cycle (only with MUX8WAY16_OUT_REG_EN).
// Backpressure: none; out follows sel and the selected word continuously.
// Ports: clk, rst_n (async, active-low) feed only the optional register;
//        bus (slave modport) carries a..h, sel, out and optionally out_q.
// Build option: define MUX8WAY16_OUT_REG_EN to add the registered copy out_q.
module mux_8way_16
   import mux_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic          clk,
   input  logic          rst_n,
   mux_8way_16_if.slave  bus
);

   logic [WIDTH-1:0] lo_word;
   logic [WIDTH-1:0] hi_word;
   logic [WIDTH-1:0] out_c;

   // Lower bank a..d and upper bank e..h share the two low select bits.
   mux_4way_16 #(.WIDTH(WIDTH)) u_lo (
      .sel (bus.sel[1:0]),
      .a   (bus.a),
      .b   (bus.b),
      .c   (bus.c),
      .d   (bus.d),
      .y   (lo_word)
   );

   mux_4way_16 #(.WIDTH(WIDTH)) u_hi (
      .sel (bus.sel[1:0]),
      .a   (bus.e),
      .b   (bus.f),
      .c   (bus.g),
      .d   (bus.h),
      .y   (hi_word)
   );

   // Final 2:1 stage on the select MSB; X/Z there resolves to all zeros.
   always_comb begin
      out_c = '0;
      case (sel_is_high(bus.sel))
         1'b0:    out_c = lo_word;
         1'b1:    out_c = hi_word;
         default: out_c = '0;
      endcase
   end

   assign bus.out = out_c;

`ifdef MUX8WAY16_OUT_REG_EN
   logic [WIDTH-1:0] out_r;

   // Registered copy of the selection; reset clears it without a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_r <= '0;
      end else begin
         out_r <= out_c;
      end
   end

   assign bus.out_q = out_r;
`else
   // Clock and reset have no load in the purely combinational build.
   logic unused_clk_rst;
   assign unused_clk_rst = &{1'b0, clk, rst_n};
`endif

endmodule

// File: tb/tb_mux_8way_16.sv
// Directed and random checks of mux_8way_16 against a lane-array reference.
// Build option: define MUX8WAY16_OUT_REG_EN to also exercise out_q.
module tb_mux_8way_16;
   import mux_pkg::*;

   localparam int W = WORD_W;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mux_8way_16_if #(.WIDTH(W)) bus ();

   mux_8way_16 #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [W-1:0] din [8];
   logic [W-1:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   task automatic drive(input logic [2:0] s);
      bus.a   = din[0];
      bus.b   = din[1];
      bus.c   = din[2];
      bus.d   = din[3];
      bus.e   = din[4];
      bus.f   = din[5];
      bus.g   = din[6];
      bus.h   = din[7];
      bus.sel = s;
      exp_q.push_back(din[s]);
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs,
                        input logic [W-1:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic sb_check(input string tag);
      logic [W-1:0] ev;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed out %h with empty scoreboard", tag, bus.out);
      end else begin
         ev = exp_q.pop_front();
         check(tag, bus.out, ev);
      end
   endtask

   // One 10 ns step: drive, sample 1 ns later (clear of clock edges), settle.
   task automatic step(input logic [2:0] s, input string tag);
      drive(s);
      #1;
      sb_check(tag);
      #9;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 8; i++) din[i] = '0;

      // Reset held: out still follows sel.
      din[3] = 16'h1234;
      drive(3'd3);
      #1;
      sb_check("rst_out_d");
`ifdef MUX8WAY16_OUT_REG_EN
      check("rst_outq", bus.out_q, '0);
`endif
      #9;
      rst_n = 1'b1;

      // One-hot lanes, sel stepped 0..7.
      for (int i = 0; i < 8; i++) din[i] = W'(1) << i;
      for (int s = 0; s < 8; s++) step(3'(s), "onehot_lane");

      // Unselected lanes toggling must not disturb out, then selected lane changes.
      for (int i = 0; i < 8; i++) if (i != 5) din[i] = 16'hFFFF;
      step(3'd5, "hold_f_0020");
      din[5] = 16'hBEEF;
      step(3'd5, "hold_f_beef");

      // Walking one on every lane and bit, at every sel.
      for (int k = 0; k < 8; k++) begin
         for (int bt = 0; bt < W; bt++) begin
            for (int i = 0; i < 8; i++) din[i] = '0;
            din[k] = W'(1) << bt;
            for (int s = 0; s < 8; s++) step(3'(s), "walk_one");
         end
      end

      // Random vectors.
      for (int n = 0; n < 1000; n++) begin
         for (int i = 0; i < 8; i++) din[i] = W'($urandom);
         step(3'($urandom_range(7, 0)), "random");
      end

`ifdef MUX8WAY16_OUT_REG_EN
      // Registered copy: zero through reset, loads one edge after release.
      rst_n = 1'b0;
      for (int i = 0; i < 8; i++) din[i] = '0;
      din[6] = 16'hA5A5;
      drive(3'd6);
      #1;
      sb_check("outq_seq_out");
      check("outq_in_rst_a", bus.out_q, '0);
      #10;
      check("outq_in_rst_b", bus.out_q, '0);
      #9;
      rst_n = 1'b1;
      #1;
      check("outq_pre_edge", bus.out_q, '0);
      #5;
      check("outq_load", bus.out_q, 16'hA5A5);
      #2;
      rst_n = 1'b0;
      #1;
      check("outq_async_clr", bus.out_q, '0);
      check("out_during_rst", bus.out, din[6]);
      #1;
      rst_n = 1'b1;
      #10;
`endif

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL sb_drain: observed %0d leftover entries expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
